// File: rtl/razor_recovery_ctrl_if.sv
// Bundle between the Razor recovery sequencer and the pipeline: per-stage error/PC in,
// flush/stall/PC-restore controls and status out. master = sequencer, slave = pipeline side.
interface razor_recovery_ctrl_if #(
    parameter int NSTAGE = 4,
    parameter int CNT_W  = 16
);
    logic [NSTAGE-1:0]    err_stage;
    logic [NSTAGE*32-1:0] pc_stage;
    logic [NSTAGE-1:0]    flush;
    logic                 stall;
    logic                 pc_sel;
    logic [31:0]          pc_restore;
    logic                 busy;
    logic                 halt;
    logic [CNT_W-1:0]     err_count;

    modport master (
        input  err_stage, pc_stage,
        output flush, stall, pc_sel, pc_restore, busy, halt, err_count
    );

    modport slave (
        output err_stage, pc_stage,
        input  flush, stall, pc_sel, pc_restore, busy, halt, err_count
    );
endinterface

// File: rtl/razor_recovery_ctrl.sv
// Razor recovery sequencer: flush oldest faulting stage and younger, restore PC, watch replay, halt after MAX_RETRY failures.
// Optional macro RAZOR_RECOVERY_STATS_EN implements err_count; otherwise err_count is tied to 0.
module razor_recovery_ctrl #(
    parameter int NSTAGE        = 4,
    parameter int REPLAY_CYCLES = 3,
    parameter int MAX_RETRY     = 3,
    parameter int CNT_W         = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    razor_recovery_ctrl_if.master bus
);
    localparam int RW = $clog2(REPLAY_CYCLES + 1);
    localparam int TW = $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_RESTORE,
        S_REPLAY,
        S_HALT
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [NSTAGE-1:0] r_kmask;
    logic [NSTAGE-1:0] w_kmask;
    logic [31:0]       r_pc_restore;
    logic [31:0]       w_pc_new;
    logic [RW-1:0]     r_replay_cnt;
    logic [TW-1:0]     r_retry;
    logic [TW-1:0]     w_retry_inc;
    logic              w_any_err;
    logic              w_retry_exhausted;
    logic              w_replay_done;
    logic              w_accept;
    logic [NSTAGE-1:0] w_flush;
    logic              w_stall;
    logic              w_pc_sel;
    logic              w_busy;
    logic              w_halt;

    // Mask bit i is set when any stage at or above i faulted, giving bits 0..k for oldest k.
    always_comb begin
        logic acc;
        acc      = 1'b0;
        w_kmask  = '0;
        w_pc_new = '0;
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            acc        = acc | bus.err_stage[i];
            w_kmask[i] = acc;
        end
        for (int i = 0; i < NSTAGE; i++) begin
            if (bus.err_stage[i]) w_pc_new = bus.pc_stage[32*i +: 32];
        end
    end

    assign w_any_err         = |bus.err_stage;
    assign w_retry_inc       = r_retry + TW'(1);
    assign w_retry_exhausted = (w_retry_inc == TW'(MAX_RETRY));
    assign w_replay_done     = (r_replay_cnt <= RW'(1));
    assign w_accept          = w_any_err &&
                               ((r_state == S_IDLE) ||
                                ((r_state == S_REPLAY) && !w_retry_exhausted));

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Errors are deliberately not examined in FLUSH/RESTORE: flushed registers can misreport.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_any_err) w_state_nxt = S_FLUSH;
            S_FLUSH:   w_state_nxt = S_RESTORE;
            S_RESTORE: w_state_nxt = S_REPLAY;
            S_REPLAY: begin
                if (w_any_err)          w_state_nxt = w_retry_exhausted ? S_HALT : S_FLUSH;
                else if (w_replay_done) w_state_nxt = S_IDLE;
            end
            S_HALT:    w_state_nxt = S_HALT;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_flush  = '0;
        w_stall  = 1'b0;
        w_pc_sel = 1'b0;
        w_busy   = 1'b1;
        w_halt   = 1'b0;
        case (r_state)
            S_IDLE:    w_busy = 1'b0;
            S_FLUSH: begin
                w_flush = r_kmask;
                w_stall = 1'b1;
            end
            S_RESTORE: w_pc_sel = 1'b1;
            S_REPLAY:  w_busy = 1'b1;
            S_HALT: begin
                w_flush = '1;
                w_stall = 1'b1;
                w_halt  = 1'b1;
            end
            default:   w_busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_kmask      <= '0;
            r_pc_restore <= '0;
            r_replay_cnt <= '0;
            r_retry      <= '0;
        end else begin
            if (w_accept) begin
                r_kmask      <= w_kmask;
                r_pc_restore <= w_pc_new;
            end
            case (r_state)
                S_RESTORE: r_replay_cnt <= RW'(REPLAY_CYCLES);
                S_REPLAY: begin
                    if (r_replay_cnt != '0) r_replay_cnt <= r_replay_cnt - RW'(1);
                    if (w_any_err)          r_retry <= w_retry_inc;
                    else if (w_replay_done) r_retry <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.flush      = w_flush;
    assign bus.stall      = w_stall;
    assign bus.pc_sel     = w_pc_sel;
    assign bus.busy       = w_busy;
    assign bus.halt       = w_halt;
    assign bus.pc_restore = r_pc_restore;

`ifdef RAZOR_RECOVERY_STATS_EN
    logic [CNT_W-1:0] r_err_count;

    always_ff @(posedge clk) begin
        if (reset)                               r_err_count <= '0;
        else if (w_accept && (r_err_count != '1)) r_err_count <= r_err_count + CNT_W'(1);
    end

    assign bus.err_count = r_err_count;
`else
    assign bus.err_count = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_razor_recovery_ctrl.sv
// Bench for razor_recovery_ctrl: directed scenarios then random errors/resets, checked each cycle
// against a schedule-based model of the recovery sequence.
module tb_razor_recovery_ctrl;
    localparam int NS = 4;
    localparam int RC = 3;
    localparam int MR = 3;
    localparam int CW = 16;

    localparam int K_FLUSH   = 0;
    localparam int K_RESTORE = 1;
    localparam int K_WATCH   = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    razor_recovery_ctrl_if #(.NSTAGE(NS), .CNT_W(CW)) bus ();

    razor_recovery_ctrl #(
        .NSTAGE(NS), .REPLAY_CYCLES(RC), .MAX_RETRY(MR), .CNT_W(CW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int          errors = 0;
    int          checks = 0;
    int          sched[$];
    bit          halted = 1'b0;
    int          retry  = 0;
    logic [31:0] m_pc   = '0;
    logic [3:0]  m_mask = '0;
    int          m_cnt  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] mkpc(input logic [31:0] p3, input logic [31:0] p2,
                                          input logic [31:0] p1, input logic [31:0] p0);
        return {p3, p2, p1, p0};
    endfunction

    task automatic model_edge(input logic rst, input logic [3:0] e, input logic [127:0] pcs);
        int  k;
        int  was;
        bit  watching;
        if (rst) begin
            sched.delete();
            halted = 1'b0;
            retry  = 0;
            m_pc   = '0;
            m_mask = '0;
            m_cnt  = 0;
            return;
        end
        if (halted) return;
        watching = (sched.size() == 0) || (sched[0] == K_WATCH);
        if (e != 4'b0 && watching) begin
            if (sched.size() != 0) begin
                retry++;
                if (retry == MR) begin
                    halted = 1'b1;
                    sched.delete();
                    return;
                end
            end
            k = 0;
            for (int i = 0; i < NS; i++) if (e[i]) k = i;
            m_pc   = pcs[32*k +: 32];
            m_mask = 4'((1 << (k + 1)) - 1);
            if (m_cnt < 65535) m_cnt++;
            sched.delete();
            sched.push_back(K_FLUSH);
            sched.push_back(K_RESTORE);
            for (int i = 0; i < RC; i++) sched.push_back(K_WATCH);
        end else if (sched.size() != 0) begin
            was = sched.pop_front();
            if (was == K_WATCH && sched.size() == 0) retry = 0;
        end
    endtask

    task automatic check_all();
        logic [3:0] x_flush;
        logic       x_stall, x_pc_sel, x_busy, x_halt;
        int         x_cnt;
        x_flush = '0; x_stall = 1'b0; x_pc_sel = 1'b0; x_busy = 1'b0; x_halt = 1'b0;
        if (halted) begin
            x_flush = 4'hF; x_stall = 1'b1; x_busy = 1'b1; x_halt = 1'b1;
        end else if (sched.size() != 0) begin
            x_busy = 1'b1;
            if (sched[0] == K_FLUSH) begin
                x_flush = m_mask;
                x_stall = 1'b1;
            end else if (sched[0] == K_RESTORE) begin
                x_pc_sel = 1'b1;
            end
        end
`ifdef RAZOR_RECOVERY_STATS_EN
        x_cnt = m_cnt;
`else
        x_cnt = 0;
`endif
        chk("flush",      32'(bus.flush),     32'(x_flush));
        chk("stall",      32'(bus.stall),     32'(x_stall));
        chk("pc_sel",     32'(bus.pc_sel),    32'(x_pc_sel));
        chk("busy",       32'(bus.busy),      32'(x_busy));
        chk("halt",       32'(bus.halt),      32'(x_halt));
        chk("pc_restore", bus.pc_restore,     m_pc);
        chk("err_count",  32'(bus.err_count), 32'(x_cnt));
    endtask

    task automatic step(input logic rst, input logic [3:0] e, input logic [127:0] pcs);
        reset         = rst;
        bus.err_stage = e;
        bus.pc_stage  = pcs;
        @(posedge clk);
        model_edge(rst, e, pcs);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        logic [127:0] pcs;
        logic [3:0]   e;
        logic         r;
        reset         = 1'b1;
        bus.err_stage = '0;
        bus.pc_stage  = '0;

        // Reset state
        step(1'b1, 4'b0, '0);
        step(1'b1, 4'b0, '0);
        step(1'b0, 4'b0, '0);

        // Single error in stage 2
        pcs = mkpc(32'h100, 32'h40, 32'h30, 32'h34);
        step(1'b0, 4'b0100, pcs);
        chk("tp1_flush", 32'(bus.flush), 32'h7);
        step(1'b0, 4'b0, pcs);
        chk("tp1_pc_sel", 32'(bus.pc_sel), 32'h1);
        chk("tp1_pc_restore", bus.pc_restore, 32'h40);
        for (int i = 0; i < 5; i++) step(1'b0, 4'b0, pcs);
        chk("tp1_idle", 32'(bus.busy), 32'h0);

        // Simultaneous errors: oldest wins
        pcs = mkpc(32'h0, 32'h0, 32'h20, 32'h24);
        step(1'b0, 4'b0011, pcs);
        chk("tp2_flush", 32'(bus.flush), 32'h3);
        chk("tp2_pc_restore", bus.pc_restore, 32'h20);
        for (int i = 0; i < 5; i++) step(1'b0, 4'b0, pcs);

        // Error in the last replay cycle counts as a failed replay
        pcs = mkpc(32'h500, 32'h400, 32'h300, 32'h200);
        step(1'b0, 4'b0001, pcs);
        for (int i = 0; i < 4; i++) step(1'b0, 4'b0, pcs);
        step(1'b0, 4'b1000, pcs);
        for (int i = 0; i < 6; i++) step(1'b0, 4'b0, pcs);

        // Persistent error: retry limit reaches HALT, held until reset
        step(1'b1, 4'b0, pcs);
        pcs = mkpc(32'hA0, 32'hB0, 32'hC0, 32'hD0);
        for (int i = 0; i < 14; i++) step(1'b0, 4'b0010, pcs);
        chk("tp3_halt", 32'(bus.halt), 32'h1);
        for (int i = 0; i < 3; i++) step(1'b0, 4'b0, pcs);

        // Error pulses only during FLUSH/RESTORE are ignored
        step(1'b1, 4'b0, pcs);
        step(1'b0, 4'b0001, pcs);
        step(1'b0, 4'b1111, pcs);
        step(1'b0, 4'b1111, pcs);
        for (int i = 0; i < 5; i++) step(1'b0, 4'b0, pcs);

        // Reset during REPLAY, then a fresh error
        step(1'b0, 4'b0100, pcs);
        step(1'b0, 4'b0, pcs);
        step(1'b0, 4'b0, pcs);
        step(1'b0, 4'b0, pcs);
        step(1'b1, 4'b0, pcs);
        pcs = mkpc(32'h1111, 32'h2222, 32'h3333, 32'h4444);
        step(1'b0, 4'b1000, pcs);
        for (int i = 0; i < 6; i++) step(1'b0, 4'b0, pcs);

        // Random errors, PCs and occasional resets
        for (int n = 0; n < 600; n++) begin
            pcs = {$urandom(), $urandom(), $urandom(), $urandom()};
            e   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
            r   = ($urandom_range(0, 59) == 0);
            step(r, e, pcs);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/razor_recovery_ctrl.md
# razor_recovery_ctrl

Pipeline error-recovery sequencer for the Razor-protected 5-stage CPU. It watches the per-stage Razor error outputs of the IF/ID, ID/EX, EX/MEM and MEM/WB registers and selects the oldest faulting stage. It then flushes that stage and every younger stage, restores the PC to the faulting instruction, and supervises a replay window. Repeated failures escalate to a sticky halt. It sits beside the hazard unit and drives the `errorin` reset inputs of the stage registers, plus the PC-source mux.

## Interface
Parameters:
- NSTAGE, 4: number of Razor pipeline registers; index 0 = IF/ID (youngest), NSTAGE-1 = MEM/WB (oldest).
- REPLAY_CYCLES, 3: length of the post-restore watch window, in cycles (≥1).
- MAX_RETRY, 3: consecutive failed replays tolerated before halt (≥1).
- CNT_W, 16: width of the error event counter.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears all state on the clk edge where it is high.
- err_stage  in  NSTAGE  per-stage Razor error (the `errorout` of each stage register).
- pc_stage  in  NSTAGE*32  PC held in each stage register; stage i is bits [32i+31:32i].
- flush  out  NSTAGE  per-stage synchronous clear, driven to each stage register's `errorin`.
- stall  out  1  freezes the PC register and the IF/ID register.
- pc_sel  out  1  1 = PC mux loads pc_restore.
- pc_restore  out  32  restart address.
- busy  out  1  high in any state other than IDLE.
- halt  out  1  sticky; retry limit exceeded.
- err_count  out  CNT_W  number of accepted error events.

## Operation
- States: IDLE, FLUSH, RESTORE, REPLAY, HALT. Reset → IDLE.
- IDLE: when err_stage ≠ 0, set k = highest set index (oldest stage wins on simultaneous errors). Latch pc_restore ← pc_stage[k] and kmask = bits 0..k set. Increment err_count. Go to FLUSH.
- FLUSH (1 cycle): flush = kmask, stall = 1. Go to RESTORE.
- RESTORE (1 cycle): pc_sel = 1, stall = 0, flush = 0; the PC loads pc_restore on this edge. Load replay counter ← REPLAY_CYCLES. Go to REPLAY.
- REPLAY: the counter decrements each cycle.
  - If any err_stage bit is set: retry ← retry+1. If the new retry equals MAX_RETRY, go to HALT. Otherwise re-latch k, pc_restore and kmask exactly as in IDLE, increment err_count, and go to FLUSH.
  - If the counter reaches 0 with no error: retry ← 0, go to IDLE.
- HALT: flush = all ones, stall = 1, halt = 1. Only reset exits this state.
- err_stage is ignored in FLUSH and RESTORE, because flushed registers may report spurious errors.
- err_count saturates at all ones and never wraps.
- In IDLE, outputs are flush = 0, stall = 0, pc_sel = 0 and busy = 0. Stages older than k are never flushed.

## Timing
- All outputs are registered, decoded from the state register.
- Reset values: flush = 0, stall = 0, pc_sel = 0, pc_restore = 0, busy = 0, halt = 0, err_count = 0. Retry and replay counters are also 0.
- Latency from an error sampled high in IDLE at edge N:
  - flush and stall high during cycle N+1.
  - pc_sel high during cycle N+2.
  - REPLAY begins at N+3.
- Minimum recovery with no further errors: 3 + REPLAY_CYCLES cycles from detection back to IDLE.
- Reset asserted mid-sequence (any state, including HALT) returns to IDLE next edge with all outputs at their reset values. An in-flight flush is abandoned.
- An error in the same cycle the replay counter hits 0 counts as a failed replay; the error takes priority over completion.

## Configuration
- RAZOR_RECOVERY_STATS_EN defined: err_count is implemented as described.
- Undefined: the counter logic is omitted and err_count is tied to 0. FSM behaviour is identical.

## Test plan
- Reset, then err_stage=4'b0100 with pc_stage[2]=0x0000_0040 → flush=4'b0111 for 1 cycle, then pc_sel=1 with pc_restore=0x40, then busy for 3 cycles, then IDLE; err_count=1.
- Simultaneous err_stage=4'b0011 with pc_stage[1]=0x20, pc_stage[0]=0x24 → pc_restore=0x20, flush=4'b0011.
- With MAX_RETRY=3, re-raise an error in every REPLAY window → the third failed replay enters HALT: flush=4'hF, stall=1, halt=1, held until reset; err_count=3.
- Error pulse during FLUSH and RESTORE only → ignored; retry stays 0 and the block returns to IDLE after the replay window.
- Reset asserted in REPLAY → next cycle all outputs are 0 and the state is IDLE; a new error is then handled normally with pc_restore latched fresh.
- Build with RAZOR_RECOVERY_STATS_EN undefined, repeat the first scenario → identical flush/pc_sel/pc_restore waveform, err_count=0 throughout.
